// File: rtl/qspi_arbiter.sv
// Arbitrates four requesters onto one QSPI controller: port 0 fixed priority, ports 1..3 round-robin.
// A granted port owns the controller for its whole burst; per-port base offset and CE map are latched at grant.
module qspi_arbiter #(
    parameter int CHIP_SELECTS = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [3:0]                i_req_valid,
    input  logic [95:0]               i_req_addr,
    input  logic [63:0]               i_req_wdata,
    input  logic [7:0]                i_req_wstrb,
    input  logic [15:0]               i_req_xfer_len,
    input  logic [4*CHIP_SELECTS-1:0] i_req_ce,
    input  logic [47:0]               i_base_addr,
    output logic [3:0]                o_req_ready,
    output logic [15:0]               o_rdata,
    output logic [1:0]                o_grant,
    output logic                      o_busy,
    output logic [23:0]               o_qspi_addr,
    output logic [15:0]               o_qspi_wdata,
    output logic [1:0]                o_qspi_wstrb,
    output logic [3:0]                o_qspi_xfer_len,
    output logic [CHIP_SELECTS-1:0]   o_qspi_ce,
    output logic                      o_qspi_valid,
    input  logic                      i_qspi_ready,
    input  logic [15:0]               i_qspi_rdata,
    output logic                      o_dbg_state
);

    // Handshake: a requester holds req_valid until its final beat; each qspi_ready
    // completes one beat and is forwarded as req_ready to the granted port only.
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [1:0]              r_grant;
    logic [1:0]              r_rr_ptr;
    logic [3:0]              r_beat_cnt;
    logic [23:0]             r_qspi_addr;
    logic [3:0]              r_xfer_len;
    logic [CHIP_SELECTS-1:0] r_ce;

    logic [23:0]             w_addr_arr  [4];
    logic [15:0]             w_base_arr  [4];
    logic [15:0]             w_wdata_arr [4];
    logic [1:0]              w_wstrb_arr [4];
    logic [3:0]              w_len_arr   [4];
    logic [CHIP_SELECTS-1:0] w_ce_arr    [4];

    logic [1:0]              w_win;
    logic [23:0]             w_trans_addr;
    logic                    w_last;
    logic                    w_arb_take;
    logic                    w_beat_inc;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_addr_arr[i]  = i_req_addr[24*i +: 24];
            w_wdata_arr[i] = i_req_wdata[16*i +: 16];
            w_wstrb_arr[i] = i_req_wstrb[2*i +: 2];
            w_len_arr[i]   = i_req_xfer_len[4*i +: 4];
            w_ce_arr[i]    = i_req_ce[CHIP_SELECTS*i +: CHIP_SELECTS];
        end
        w_base_arr[0] = 16'h0000;
        w_base_arr[1] = i_base_addr[15:0];
        w_base_arr[2] = i_base_addr[31:16];
        w_base_arr[3] = i_base_addr[47:32];
    end

    // Search starts just after the last round-robin winner, wrapping within 1..3.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] valid);
        logic [1:0] p;
        logic [1:0] res;
        logic       hit;
        res = 2'd0;
        hit = 1'b0;
        p   = ptr;
        for (int k = 0; k < 3; k++) begin
            p = (p == 2'd3) ? 2'd1 : p + 2'd1;
            if (!hit && valid[p]) begin
                res = p;
                hit = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        w_win        = i_req_valid[0] ? 2'd0 : rr_pick(r_rr_ptr, i_req_valid);
        w_trans_addr = w_addr_arr[w_win] + {w_base_arr[w_win], 8'h00};
    end

    assign w_last = (r_beat_cnt == r_xfer_len);

    always_comb begin
        w_state_nxt = r_state;
        w_arb_take  = 1'b0;
        w_beat_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|i_req_valid) begin
                    w_arb_take  = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (i_qspi_ready) begin
                    if (w_last) w_state_nxt = ST_IDLE;
                    else        w_beat_inc  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_grant     <= 2'd0;
            r_rr_ptr    <= 2'd3;
            r_beat_cnt  <= 4'd0;
            r_qspi_addr <= 24'd0;
            r_xfer_len  <= 4'd0;
            r_ce        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_arb_take) begin
                r_grant     <= w_win;
                r_qspi_addr <= w_trans_addr;
                r_xfer_len  <= w_len_arr[w_win];
                r_ce        <= w_ce_arr[w_win];
                r_beat_cnt  <= 4'd0;
                if (w_win != 2'd0) r_rr_ptr <= w_win;
            end else if (w_beat_inc) begin
                r_beat_cnt <= r_beat_cnt + 4'd1;
            end
        end
    end

    // Valid drops combinationally on the final beat so the controller cannot restart.
    assign o_qspi_valid    = (r_state == ST_BUSY) && !(i_qspi_ready && w_last);
    assign o_req_ready     = ((r_state == ST_BUSY) && i_qspi_ready) ? (4'b0001 << r_grant) : 4'b0000;
    assign o_rdata         = i_qspi_rdata;
    assign o_grant         = r_grant;
    assign o_busy          = (r_state == ST_BUSY);
    assign o_qspi_addr     = r_qspi_addr;
    assign o_qspi_xfer_len = r_xfer_len;
    assign o_qspi_ce       = r_ce;
    assign o_qspi_wdata    = w_wdata_arr[r_grant];
    assign o_qspi_wstrb    = w_wstrb_arr[r_grant];
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_qspi_arbiter.sv
// Bench for qspi_arbiter: arbitration vector table, hand-written burst/priority/reset sequences,
// and a randomized run checked every cycle against a burst-level reference model.
module tb_qspi_arbiter;

    localparam int CS = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [95:0]   req_addr;
    logic [63:0]   req_wdata;
    logic [7:0]    req_wstrb;
    logic [15:0]   req_xfer_len;
    logic [4*CS-1:0] req_ce;
    logic [47:0]   base_addr;
    logic [3:0]    req_ready;
    logic [15:0]   rdata;
    logic [1:0]    grant;
    logic          busy;
    logic [23:0]   qspi_addr;
    logic [15:0]   qspi_wdata;
    logic [1:0]    qspi_wstrb;
    logic [3:0]    qspi_xfer_len;
    logic [CS-1:0] qspi_ce;
    logic          qspi_valid;
    logic          qspi_ready;
    logic [15:0]   qspi_rdata;
    logic          dbg_state;

    int n_vec = 0;
    int n_err = 0;

    qspi_arbiter #(.CHIP_SELECTS(CS)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb), .i_req_xfer_len(req_xfer_len),
        .i_req_ce(req_ce), .i_base_addr(base_addr), .o_req_ready(req_ready), .o_rdata(rdata),
        .o_grant(grant), .o_busy(busy), .o_qspi_addr(qspi_addr), .o_qspi_wdata(qspi_wdata),
        .o_qspi_wstrb(qspi_wstrb), .o_qspi_xfer_len(qspi_xfer_len), .o_qspi_ce(qspi_ce),
        .o_qspi_valid(qspi_valid), .i_qspi_ready(qspi_ready), .i_qspi_rdata(qspi_rdata),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    // ---------------- reference model (burst level) ----------------
    bit          m_busy;
    int          m_grant;
    int          m_rr;
    int          m_left;      // beats still to come after the current one
    logic [23:0] m_addr;
    logic [3:0]  m_len;
    logic [1:0]  m_ce;

    function automatic void model_reset();
        m_busy = 0; m_grant = 0; m_rr = 3; m_left = 0;
        m_addr = 24'd0; m_len = 4'd0; m_ce = 2'd0;
    endfunction

    function automatic int pick(input logic [3:0] v, input int rr);
        if (v[0]) return 0;
        for (int k = 1; k <= 3; k++) begin
            int p;
            p = (rr - 1 + k) % 3 + 1;
            if (v[p]) return p;
        end
        return -1;
    endfunction

    function automatic void model_step();
        if (!rst_n) begin
            model_reset();
        end else if (!m_busy) begin
            int w;
            w = pick(req_valid, m_rr);
            if (w >= 0) begin
                logic [95:0] a_sh;
                logic [47:0] b_sh;
                logic [15:0] l_sh;
                logic [7:0]  c_sh;
                int unsigned a, b, sum;
                a_sh = req_addr >> (24 * w);
                a = a_sh[23:0];
                b = 0;
                if (w != 0) begin
                    b_sh = base_addr >> (16 * (w - 1));
                    b = b_sh[15:0];
                end
                sum = (a + b * 256) % 32'h0100_0000;
                l_sh = req_xfer_len >> (4 * w);
                c_sh = req_ce >> (CS * w);
                m_addr  = sum[23:0];
                m_len   = l_sh[3:0];
                m_ce    = c_sh[1:0];
                m_left  = int'(l_sh[3:0]);
                m_grant = w;
                m_busy  = 1;
                if (w != 0) m_rr = w;
            end
        end else if (qspi_ready) begin
            if (m_left == 0) m_busy = 0;
            else m_left--;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [63:0] wd_sh;
        logic [7:0]  ws_sh;
        wd_sh = req_wdata >> (16 * m_grant);
        ws_sh = req_wstrb >> (2 * m_grant);
        chk("grant", grant, m_grant);
        chk("busy", busy, m_busy);
        chk("qspi_valid", qspi_valid, m_busy && !(qspi_ready && m_left == 0));
        chk("req_ready", req_ready, (m_busy && qspi_ready) ? (32'd1 << m_grant) : 32'd0);
        chk("qspi_addr", qspi_addr, m_addr);
        chk("qspi_xfer_len", qspi_xfer_len, m_len);
        chk("qspi_ce", qspi_ce, m_ce);
        chk("qspi_wdata", qspi_wdata, wd_sh[15:0]);
        chk("qspi_wstrb", qspi_wstrb, ws_sh[1:0]);
        chk("rdata", rdata, qspi_rdata);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_valid = 4'd0; qspi_ready = 1'b0; qspi_rdata = 16'd0;
        req_wdata = 64'd0; req_wstrb = 8'd0; req_xfer_len = 16'd0;
        req_ce = {2'd3, 2'd2, 2'd1, 2'd0};
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [23:0] addr;
        logic [15:0] base;
        logic [1:0]  exp_grant;
        logic [23:0] exp_addr;
        logic [1:0]  exp_ce;
    } vec_t;

    vec_t       tbl [7];
    logic [1:0] exp_q [$];
    logic [1:0] got_q [$];

    initial begin
        tbl[0] = '{4'b0010, 24'h000034, 16'h0012, 2'd1, 24'h001234, 2'd1};
        tbl[1] = '{4'b1000, 24'h000100, 16'hFFFF, 2'd3, 24'h000000, 2'd3};
        tbl[2] = '{4'b0111, 24'h000034, 16'h0012, 2'd0, 24'h000034, 2'd0};
        tbl[3] = '{4'b1100, 24'h000034, 16'h0012, 2'd2, 24'h001234, 2'd2};
        tbl[4] = '{4'b0001, 24'hABCDEF, 16'h1234, 2'd0, 24'hABCDEF, 2'd0};
        tbl[5] = '{4'b0100, 24'hFFFFFF, 16'h0001, 2'd2, 24'h0000FF, 2'd2};
        tbl[6] = '{4'b1110, 24'h123456, 16'h0100, 2'd1, 24'h133456, 2'd1};

        req_addr = 96'd0; base_addr = 48'd0;
        do_reset();
        chk("reset_grant", grant, 2'd0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_valid", qspi_valid, 1'b0);
        chk("reset_addr", qspi_addr, 24'd0);

        // Table: single-beat read from reset, one vector per entry.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            req_addr  = {4{tbl[i].addr}};
            base_addr = {3{tbl[i].base}};
            req_valid = tbl[i].valid;
            #1; check_all();
            tick(); #1; check_all();
            chk("tbl_grant", grant, tbl[i].exp_grant);
            chk("tbl_addr", qspi_addr, tbl[i].exp_addr);
            chk("tbl_ce", qspi_ce, tbl[i].exp_ce);
            qspi_ready = 1'b1; qspi_rdata = 16'hBEEF;
            #1; check_all();
            chk("tbl_ready", req_ready, 4'b0001 << tbl[i].exp_grant);
            chk("tbl_rdata", rdata, 16'hBEEF);
            chk("tbl_valid_drop", qspi_valid, 1'b0);
            tick();
            qspi_ready = 1'b0; req_valid = 4'd0;
            #1; check_all();
            chk("tbl_busy_after", busy, 1'b0);
        end

        // Burst write on port 3, four beats with changing data.
        do_reset();
        req_xfer_len = 16'h3333; req_wstrb = 8'b1100_0000; req_valid = 4'b1000;
        tick();
        for (int b = 0; b < 4; b++) begin
            logic [15:0] wd;
            wd = 16'h1000 + 16'(b * 16'h0111);
            req_wdata = {wd, 48'h0};
            qspi_ready = 1'b1;
            #1; check_all();
            chk("bw_wdata", qspi_wdata, wd);
            chk("bw_wstrb", qspi_wstrb, 2'b11);
            chk("bw_ready", req_ready, 4'b1000);
            chk("bw_valid", qspi_valid, (b == 3) ? 1'b0 : 1'b1);
            tick();
        end
        qspi_ready = 1'b0; req_valid = 4'd0;
        #1; check_all();
        chk("bw_done", busy, 1'b0);

        // Round-robin with ports 1..3 continuously valid.
        do_reset();
        req_valid = 4'b1110; qspi_ready = 1'b1;
        exp_q = {2'd1, 2'd2, 2'd3, 2'd1};
        got_q = {};
        for (int c = 0; c < 8; c++) begin
            #1; check_all();
            if (c % 2 == 0) chk("rr_dead_cycle", busy, 1'b0);
            else got_q.push_back(grant);
            tick();
        end
        qspi_ready = 1'b0; req_valid = 4'd0;
        chk("rr_count", got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk("rr_grant", got_q.pop_front(), exp_q.pop_front());

        // Debug port arrives during a port-2 burst with 1 and 3 pending.
        do_reset();
        req_xfer_len = 16'h3333; req_valid = 4'b0100;
        tick(); #1; check_all();
        chk("dp_first", grant, 2'd2);
        req_valid = 4'b1111; qspi_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin #1; check_all(); tick(); end
        req_valid = 4'b1011; qspi_ready = 1'b0;
        #1; check_all();
        chk("dp_dead", busy, 1'b0);
        tick(); #1; check_all();
        chk("dp_port0", grant, 2'd0);
        qspi_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin #1; check_all(); tick(); end
        req_valid = 4'b1010; qspi_ready = 1'b0;
        tick(); #1; check_all();
        chk("dp_next_rr", grant, 2'd3);

        // Asynchronous reset after two beats of a four-beat burst.
        do_reset();
        req_xfer_len = 16'h3333; req_valid = 4'b0010;
        tick();
        qspi_ready = 1'b1;
        tick(); tick();
        qspi_ready = 1'b0;
        #2; rst_n = 1'b0;
        #1;
        chk("ar_valid", qspi_valid, 1'b0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_grant", grant, 2'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; req_valid = 4'b1110;
        #1; check_all();
        tick(); #1; check_all();
        chk("ar_first_after", grant, 2'd1);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) req_valid = 4'($urandom_range(0, 15));
            req_addr     = {$urandom, $urandom, $urandom};
            base_addr    = 48'({$urandom, $urandom});
            req_xfer_len = 16'($urandom) & 16'h3333;
            req_wdata    = {$urandom, $urandom};
            req_wstrb    = 8'($urandom);
            req_ce       = 8'($urandom);
            qspi_ready   = 1'($urandom_range(0, 1));
            qspi_rdata   = 16'($urandom);
            #1; check_all();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
